// File: rtl/alu_md_seq_if.sv
// Operation/result bus of the MAD_RISC execute unit. The unit owns the slave modport.
// Valid/ready: a transfer happens on a rising edge where both VLD and RDY are high. The
// producer holds its payload stable while VLD is high, and it does not drop VLD until that transfer.
interface alu_md_seq_if #(
  parameter int XLEN = 32
);
  logic            IN_VLD;
  logic            IN_RDY;
  logic [4:0]      OPC;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            CIN;
  logic            OUT_VLD;
  logic            OUT_RDY;
  logic [XLEN-1:0] RSLT;
  logic            ZR;
  logic            NEG;
  logic            OFLW;
  logic            COUT;
  logic            BUSY;
  logic [1:0]      dbg_state;

  modport master (
    output IN_VLD, OPC, A, B, CIN, OUT_RDY,
    input  IN_RDY, OUT_VLD, RSLT, ZR, NEG, OFLW, COUT, BUSY, dbg_state
  );

  modport slave (
    input  IN_VLD, OPC, A, B, CIN, OUT_RDY,
    output IN_RDY, OUT_VLD, RSLT, ZR, NEG, OFLW, COUT, BUSY, dbg_state
  );
endinterface

// File: rtl/alu_md_seq.sv
// Execute unit: single-cycle ALU ops plus iterative radix-2 multiply and restoring divide.
// The result and flags are registered and held until the consumer takes them.
module alu_md_seq #(
  parameter int XLEN = 32
) (
  input  logic         CLK,
  input  logic         RST,
  alu_md_seq_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLL    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, RES = 2'd2} state_t;
  state_t state, state_nxt;

  logic [XLEN-1:0] a, b;
  logic [4:0]      opc;
  logic [SHW-1:0]  shamt;
  logic            in_rdy, out_vld, busy, accept;

  assign a      = bus.A;
  assign b      = bus.B;
  assign opc    = bus.OPC;
  assign shamt  = b[SHW-1:0];
  assign accept = bus.IN_VLD & in_rdy;

  // Decode: divide special cases resolve in one cycle instead of iterating.
  logic is_md, is_div, div_sgn, b_zero, div_ovf, is_iter;
  assign is_md   = (opc >= OP_MUL) && (opc <= OP_REMU);
  assign is_div  = (opc >= OP_DIV) && (opc <= OP_REMU);
  assign div_sgn = (opc == OP_DIV) || (opc == OP_REM);
  assign b_zero  = (b == '0);
  assign div_ovf = div_sgn && (a == SMIN) && (b == '1);
  assign is_iter = is_md && !(is_div && (b_zero || div_ovf));

  // Single-cycle result path
  logic [XLEN:0]   add_w, sub_w;
  logic [XLEN-1:0] sc_rslt;
  logic            sc_oflw, sc_cout;

  assign add_w = {1'b0, a} + {1'b0, b} + {{XLEN{1'b0}}, bus.CIN};
  assign sub_w = {1'b0, a} - {1'b0, b} - {{XLEN{1'b0}}, bus.CIN};

  always_comb begin
    sc_rslt = '0;
    sc_oflw = 1'b0;
    sc_cout = 1'b0;
    case (opc)
      OP_ADD: begin
        sc_rslt = add_w[XLEN-1:0];
        sc_cout = add_w[XLEN];
        sc_oflw = (a[XLEN-1] == b[XLEN-1]) && (add_w[XLEN-1] != a[XLEN-1]);
      end
      OP_SUB: begin
        sc_rslt = sub_w[XLEN-1:0];
        sc_cout = sub_w[XLEN];
        sc_oflw = (a[XLEN-1] != b[XLEN-1]) && (sub_w[XLEN-1] != a[XLEN-1]);
      end
      OP_AND:  sc_rslt = a & b;
      OP_OR:   sc_rslt = a | b;
      OP_XOR:  sc_rslt = a ^ b;
      OP_SLL:  sc_rslt = a << shamt;
      OP_SRL:  sc_rslt = a >> shamt;
      OP_SRA:  sc_rslt = $signed(a) >>> shamt;
      OP_SLT:  sc_rslt = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_rslt = {{(XLEN-1){1'b0}}, (a < b)};
      OP_DIV, OP_DIVU: sc_rslt = b_zero ? '1 : a;
      OP_REM, OP_REMU: sc_rslt = b_zero ? a : '0;
      default: sc_rslt = '0;
    endcase
  end

  // Iterative path works on magnitudes; the sign is restored on the final step.
  logic            a_neg, b_neg, neg_nxt;
  logic [XLEN-1:0] a_mag, b_mag;
  assign a_neg   = a[XLEN-1] && ((opc == OP_MULH) || (opc == OP_MULHSU) || div_sgn);
  assign b_neg   = b[XLEN-1] && ((opc == OP_MULH) || div_sgn);
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;
  assign neg_nxt = (opc == OP_REM) ? a_neg : (a_neg ^ b_neg);

  logic [XLEN-1:0] acc_q, sh_q, opnd_q;
  logic [SHW-1:0]  cnt_q;
  logic [4:0]      op_q;
  logic            neg_q, op_is_div;
  assign op_is_div = (op_q >= OP_DIV);

  logic [XLEN:0]     mul_sum, div_rs, div_diff;
  logic [XLEN-1:0]   mul_acc_n, mul_sh_n, div_acc_n, div_sh_n;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, it_rslt;
  logic              div_ge;

  assign mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_acc_n = mul_sum[XLEN:1];
  assign mul_sh_n  = {mul_sum[0], sh_q[XLEN-1:1]};
  assign div_rs    = {acc_q, sh_q[XLEN-1]};
  assign div_diff  = div_rs - {1'b0, opnd_q};
  assign div_ge    = !div_diff[XLEN];
  assign div_acc_n = div_ge ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0];
  assign div_sh_n  = {sh_q[XLEN-2:0], div_ge};

  assign prod   = {mul_acc_n, mul_sh_n};
  assign prod_s = neg_q ? -prod : prod;
  assign quo_s  = neg_q ? -div_sh_n : div_sh_n;
  assign rem_s  = neg_q ? -div_acc_n : div_acc_n;

  always_comb begin
    it_rslt = rem_s;
    case (op_q)
      OP_MUL:                        it_rslt = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  it_rslt = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               it_rslt = quo_s;
      default:                       it_rslt = rem_s;
    endcase
  end

  // Result register load select
  logic            ld, ld_oflw, ld_cout;
  logic [XLEN-1:0] ld_val;
  always_comb begin
    ld      = 1'b0;
    ld_val  = sc_rslt;
    ld_oflw = sc_oflw;
    ld_cout = sc_cout;
    if (state == ITER) begin
      ld      = (cnt_q == LAST);
      ld_val  = it_rslt;
      ld_oflw = 1'b0;
      ld_cout = 1'b0;
    end else if (accept && !is_iter) begin
      ld = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (bus.IN_VLD) state_nxt = is_iter ? ITER : RES;
      end
      ITER: begin
        busy = 1'b1;
        if (cnt_q == LAST) state_nxt = RES;
      end
      RES: begin
        out_vld = 1'b1;
        in_rdy  = bus.OUT_RDY;
        if (bus.OUT_RDY) state_nxt = bus.IN_VLD ? (is_iter ? ITER : RES) : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      bus.RSLT <= '0;
      bus.ZR   <= 1'b0;
      bus.NEG  <= 1'b0;
      bus.OFLW <= 1'b0;
      bus.COUT <= 1'b0;
      acc_q    <= '0;
      sh_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ld) begin
        bus.RSLT <= ld_val;
        bus.ZR   <= (ld_val == '0);
        bus.NEG  <= ld_val[XLEN-1];
        bus.OFLW <= ld_oflw;
        bus.COUT <= ld_cout;
      end
      if (accept && is_iter) begin
        acc_q  <= '0;
        sh_q   <= a_mag;
        opnd_q <= b_mag;
        cnt_q  <= '0;
        op_q   <= opc;
        neg_q  <= neg_nxt;
      end else if (state == ITER) begin
        acc_q <= op_is_div ? div_acc_n : mul_acc_n;
        sh_q  <= op_is_div ? div_sh_n : mul_sh_n;
        cnt_q <= cnt_q + SHW'(1);
      end
    end
  end

  assign bus.IN_RDY    = in_rdy;
  assign bus.OUT_VLD   = out_vld;
  assign bus.BUSY      = busy;
  assign bus.dbg_state = state;
endmodule
